// File: rtl/painel_scroll_driver.sv
// painel_scroll_driver: scrolls a message from a writable character buffer
// across a 4-digit multiplexed 7-segment panel. The divider's scan and scroll
// square waves are sampled as data, synchronized and edge-detected into
// single-cycle enables within the system clock domain.
module painel_scroll_driver #(
  parameter int MSG_DEPTH = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              div_scan,
  input  logic              div_scroll,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [4:0]        wr_data,
  input  logic              len_we,
  input  logic [ADDR_W:0]   len_data,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              dir,
  output logic [6:0]        seg,
  output logic [3:0]        an,
  output logic              running,
  output logic [ADDR_W-1:0] pos
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MSG_DEPTH);

  state_t            state_q;
  logic [1:0]        dig_q;
  logic [ADDR_W:0]   len_q;
  logic [4:0]        msg_buf [MSG_DEPTH];

  logic [2:0]        scan_sync;
  logic [2:0]        scroll_sync;
  logic              scan_p;
  logic              scroll_p;

  logic [ADDR_W:0]   len_new;
  logic [ADDR_W:0]   len_eff;
  logic [ADDR_W-1:0] pos_base;
  logic [ADDR_W:0]   pos_inc;
  logic [ADDR_W-1:0] pos_fwd;
  logic [ADDR_W-1:0] pos_bwd;
  logic [1:0]        dig_nxt;
  logic [ADDR_W-1:0] disp_pos;
  logic [ADDR_W+1:0] disp_sum;
  logic [ADDR_W-1:0] disp_idx;
  logic [3:0]        an_nxt;
  logic [6:0]        seg_nxt;

  // Character code to active-low segment pattern {g,f,e,d,c,b,a}
  function automatic logic [6:0] decode(input logic [4:0] c);
    logic [6:0] s;
    case (c)
      5'd0:    s = 7'h40;
      5'd1:    s = 7'h79;
      5'd2:    s = 7'h24;
      5'd3:    s = 7'h30;
      5'd4:    s = 7'h19;
      5'd5:    s = 7'h12;
      5'd6:    s = 7'h02;
      5'd7:    s = 7'h78;
      5'd8:    s = 7'h00;
      5'd9:    s = 7'h10;
      5'd10:   s = 7'h08;
      5'd11:   s = 7'h03;
      5'd12:   s = 7'h46;
      5'd13:   s = 7'h21;
      5'd14:   s = 7'h06;
      5'd15:   s = 7'h0E;
      5'd17:   s = 7'h3F;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Two-stage synchronizers plus one history stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_sync   <= '0;
      scroll_sync <= '0;
    end else begin
      scan_sync   <= {scan_sync[1:0], div_scan};
      scroll_sync <= {scroll_sync[1:0], div_scroll};
    end
  end

  assign scan_p   = scan_sync[1] & ~scan_sync[2];
  assign scroll_p = scroll_sync[1] & ~scroll_sync[2];

  // Character buffer: writes land in any state, reset fills with blanks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MSG_DEPTH; i++) msg_buf[i] <= 5'd16;
    end else if (wr_en) begin
      msg_buf[wr_addr] <= wr_data;
    end
  end

  // Effective length this cycle and the position arithmetic derived from it;
  // a same-cycle length write is applied before any wrap so the step uses it
  always_comb begin
    len_new  = (len_data > DEPTH_L) ? DEPTH_L : len_data;
    len_eff  = len_we ? len_new : len_q;
    pos_base = ({1'b0, pos} >= len_eff) ? '0 : pos;
    pos_inc  = {1'b0, pos_base} + (ADDR_W+1)'(1);
    pos_fwd  = (pos_inc >= len_eff) ? '0 : ADDR_W'(pos_inc);
    pos_bwd  = (pos_base == '0) ? ADDR_W'(len_eff - (ADDR_W+1)'(1))
                                : pos_base - ADDR_W'(1);
  end

  // Next digit and its display content; (pos+digit) mod len needs at most
  // three subtractions because pos < len and digit <= 3
  always_comb begin
    dig_nxt  = scan_p ? dig_q + 2'd1 : dig_q;
    disp_pos = (state_q == IDLE) ? '0 : pos_base;
    disp_sum = (ADDR_W+2)'(disp_pos) + (ADDR_W+2)'(dig_nxt);
    for (int unsigned i = 0; i < 3; i++) begin
      if (len_eff != '0 && disp_sum >= (ADDR_W+2)'(len_eff))
        disp_sum = disp_sum - (ADDR_W+2)'(len_eff);
    end
    disp_idx = ADDR_W'(disp_sum);
    an_nxt   = ~(4'b0001 << dig_nxt);
    seg_nxt  = decode(msg_buf[disp_idx]);
  end

  // Control FSM with registered display outputs, position and length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pos     <= '0;
      dig_q   <= '0;
      len_q   <= '0;
      an      <= 4'hF;
      seg     <= 7'h7F;
      running <= 1'b0;
    end else begin
      dig_q <= dig_nxt;
      if (len_we) len_q <= len_new;
      case (state_q)
        IDLE: begin
          pos     <= pos_base;
          an      <= 4'hF;
          seg     <= 7'h7F;
          running <= 1'b0;
          if (start && !stop && len_eff != '0) begin
            state_q <= RUN;
            pos     <= '0;
            running <= 1'b1;
            an      <= an_nxt;
            seg     <= seg_nxt;
          end
        end
        RUN, PAUSE: begin
          pos <= pos_base;
          if (stop || (len_we && len_new == '0)) begin
            state_q <= IDLE;
            running <= 1'b0;
            an      <= 4'hF;
            seg     <= 7'h7F;
          end else begin
            if (scan_p) begin
              an  <= an_nxt;
              seg <= seg_nxt;
            end
            if (state_q == RUN) begin
              if (pause)         state_q <= PAUSE;
              else if (scroll_p) pos     <= dir ? pos_bwd : pos_fwd;
            end else if (!pause) begin
              state_q <= RUN;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_painel_scroll_driver.sv
// Directed bench for painel_scroll_driver with hand-computed expectations.
module tb_painel_scroll_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       div_scan = 1'b0;
  logic       div_scroll = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic       len_we = 1'b0;
  logic [4:0] len_data = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       dir = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       running;
  logic [3:0] pos;

  int passed = 0;
  int total  = 0;

  painel_scroll_driver #(.MSG_DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .div_scan(div_scan), .div_scroll(div_scroll),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len_we(len_we), .len_data(len_data), .start(start), .stop(stop),
    .pause(pause), .dir(dir), .seg(seg), .an(an), .running(running), .pos(pos)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [4:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic set_len(input logic [4:0] n);
    len_we = 1'b1; len_data = n;
    tick();
    len_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic scan_pulse();
    div_scan = 1'b1;
    repeat (4) tick();
    div_scan = 1'b0;
    repeat (4) tick();
  endtask

  task automatic scroll_pulse();
    div_scroll = 1'b1;
    repeat (4) tick();
    div_scroll = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 16; i++) wr(4'(i), 5'(i));
    set_len(5'd16);
    do_start();
    scroll_pulse();
    total++;
    if (pos !== 4'd1) $display("FAIL reset_pre_pos: got %0d want 1", pos); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (seg !== 7'h7F || an !== 4'hF || running !== 1'b0 || pos !== 4'd0)
      $display("FAIL reset_async: seg=%h an=%h run=%b pos=%0d want 7f f 0 0", seg, an, running, pos);
    else passed++;
    #2 rst_n = 1'b1;
    tick();
    set_len(5'd16);
    do_start();
    total++;
    if (seg !== 7'h7F || an !== 4'hE)
      $display("FAIL reset_buf_first: seg=%h an=%h want 7f e", seg, an);
    else passed++;
    for (int k = 0; k < 16; k++) begin
      scan_pulse();
      total++;
      if (seg !== 7'h7F) $display("FAIL reset_buf_blank %0d: seg=%h want 7f", k, seg);
      else passed++;
      if (k % 4 == 3 && k != 15) repeat (4) scroll_pulse();
    end
  endtask

  task automatic test_edge_sync();
    do_reset();
    for (int i = 0; i < 4; i++) wr(4'(i), 5'(i));
    set_len(5'd4);
    do_start();
    total++;
    if (an !== 4'hE || seg !== 7'h40) $display("FAIL sync_start: an=%h seg=%h want e 40", an, seg);
    else passed++;
    div_scan = 1'b1;
    tick();
    tick();
    total++;
    if (an !== 4'hE) $display("FAIL sync_early: an=%h want e", an); else passed++;
    tick();
    total++;
    if (an !== 4'hD || seg !== 7'h79) $display("FAIL sync_step: an=%h seg=%h want d 79", an, seg);
    else passed++;
    repeat (97) tick();
    total++;
    if (an !== 4'hD) $display("FAIL sync_held: an=%h want d", an); else passed++;
    div_scan = 1'b0;
    repeat (6) tick();
    total++;
    if (an !== 4'hD) $display("FAIL sync_fall: an=%h want d", an); else passed++;
  endtask

  task automatic test_forward();
    logic [3:0] exp_pos [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};
    logic [3:0] exp_an  [4] = '{4'hD, 4'hB, 4'h7, 4'hE};
    logic [6:0] exp_seg [4] = '{7'h79, 7'h24, 7'h30, 7'h02};
    do_reset();
    for (int i = 0; i < 6; i++) wr(4'(i), 5'(i + 1));
    set_len(5'd6);
    do_start();
    total++;
    if (pos !== 4'd0 || running !== 1'b1) $display("FAIL fwd_start: pos=%0d run=%b want 0 1", pos, running);
    else passed++;
    for (int i = 0; i < 7; i++) begin
      scroll_pulse();
      total++;
      if (pos !== exp_pos[i]) $display("FAIL fwd_pos %0d: got %0d want %0d", i, pos, exp_pos[i]);
      else passed++;
    end
    repeat (4) scroll_pulse();
    total++;
    if (pos !== 4'd5) $display("FAIL fwd_pos5: got %0d want 5", pos); else passed++;
    for (int d = 0; d < 4; d++) begin
      scan_pulse();
      total++;
      if (an !== exp_an[d] || seg !== exp_seg[d])
        $display("FAIL fwd_digit %0d: an=%h seg=%h want %h %h", d, an, seg, exp_an[d], exp_seg[d]);
      else passed++;
    end
  endtask

  task automatic test_back_pause_len();
    do_reset();
    for (int i = 0; i < 6; i++) wr(4'(i), 5'(i + 1));
    set_len(5'd6);
    do_start();
    dir = 1'b1;
    scroll_pulse();
    total++;
    if (pos !== 4'd5) $display("FAIL back_wrap: got %0d want 5", pos); else passed++;
    pause = 1'b1;
    tick();
    repeat (3) scroll_pulse();
    total++;
    if (pos !== 4'd5 || running !== 1'b1) $display("FAIL pause_hold: pos=%0d run=%b want 5 1", pos, running);
    else passed++;
    pause = 1'b0;
    tick();
    scroll_pulse();
    total++;
    if (pos !== 4'd4) $display("FAIL back_step: got %0d want 4", pos); else passed++;
    dir = 1'b0;
    scroll_pulse();
    total++;
    if (pos !== 4'd5) $display("FAIL fwd_to5: got %0d want 5", pos); else passed++;
    set_len(5'd3);
    total++;
    if (pos !== 4'd0 || running !== 1'b1) $display("FAIL len_shrink: pos=%0d run=%b want 0 1", pos, running);
    else passed++;
    set_len(5'd0);
    total++;
    if (running !== 1'b0 || an !== 4'hF || seg !== 7'h7F || pos !== 4'd0)
      $display("FAIL len_zero: run=%b an=%h seg=%h pos=%0d want 0 f 7f 0", running, an, seg, pos);
    else passed++;
  endtask

  task automatic test_corners();
    do_reset();
    do_start();
    total++;
    if (running !== 1'b0 || an !== 4'hF) $display("FAIL start_len0: run=%b an=%h want 0 f", running, an);
    else passed++;
    set_len(5'd4);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    total++;
    if (running !== 1'b0 || an !== 4'hF) $display("FAIL start_stop: run=%b an=%h want 0 f", running, an);
    else passed++;
    do_reset();
    set_len(5'd1);
    wr(4'd0, 5'd17);
    do_start();
    total++;
    if (seg !== 7'h3F || an !== 4'hE) $display("FAIL dash: seg=%h an=%h want 3f e", seg, an);
    else passed++;
    wr(4'd0, 5'd25);
    scan_pulse();
    total++;
    if (seg !== 7'h7F || an !== 4'hD) $display("FAIL code25_wrap: seg=%h an=%h want 7f d", seg, an);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_edge_sync();
    test_forward();
    test_back_pause_len();
    test_corners();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/painel_scroll_driver.md
Name: painel_scroll_driver

Overview:
- Display stage directly downstream of the panel's frequency divider.
- Consumes the divider's two square-wave outputs: the fast scan rate (clkCONT, 2^16 division) and the slow scroll rate (clkRU, 2^24 division).
- Both divider outputs are sampled as data in the single system clock domain; they are never used as clocks.
- Drives a 4-digit multiplexed 7-segment panel that scrolls a message held in a writable character buffer.

Parameters:
- MSG_DEPTH, 16: number of character slots in the message buffer.
- ADDR_W, 4: buffer address width; must satisfy 2^ADDR_W = MSG_DEPTH.

Ports:
- clk  in  1  system clock, the same clock that feeds the divider.
- rst_n  in  1  asynchronous, active-low reset.
- div_scan  in  1  divider output clkCONT, square wave.
- div_scroll  in  1  divider output clkRU, square wave.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  ADDR_W  buffer slot to write.
- wr_data  in  5  character code to write.
- len_we  in  1  message-length write strobe.
- len_data  in  ADDR_W+1  new message length, valid range 0..MSG_DEPTH.
- start  in  1  single-cycle pulse: begin scrolling.
- stop  in  1  single-cycle pulse: return to IDLE.
- pause  in  1  level: while high, hold the scroll position.
- dir  in  1  scroll direction; 0 = forward (pos+1), 1 = backward (pos-1).
- seg  out  7  segment outputs {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit anodes, active-low, one-hot.
- running  out  1  high in RUN or PAUSE.
- pos  out  ADDR_W  index of the message character shown on digit 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, pos = 0, digit index = 0, length = 0.
  - All buffer slots = 16 (blank).
  - seg = 7'h7F, an = 4'hF, running = 0.
- Input conditioning:
  - div_scan and div_scroll each pass through a 2-FF synchronizer, then a rising-edge detector.
  - Each rising edge yields a 1-clk pulse, scan_p or scroll_p, asserted 3 clk after the input edge.
  - A level held high produces exactly one pulse.
- Scan path:
  - The digit index advances 0→1→2→3→0 on each scan_p, in every state.
  - an = ~(1<<digit), registered.
  - seg = decode(buf[(pos+digit) mod len]), registered; an and seg update in the same clk.
- Character decode:
  - 0..9: digits 0..9.
  - 10..15: A,b,C,d,E,F.
  - 16: blank.
  - 17: '-' (only g lit).
  - 18..31: blank.
- Buffer writes:
  - A write with wr_en=1 completes at the clk edge where it is sampled, in any state.
  - A modified slot is visible at the next display register update.
- States:
  - IDLE:
    - an = 4'hF, seg = 7'h7F, running = 0.
    - start with len≥1 → RUN, pos = 0.
    - start with len=0 is ignored.
  - RUN:
    - On scroll_p with pause=0: pos = (pos+1) mod len when dir=0, (pos-1+len) mod len when dir=1.
    - pause=1 → PAUSE.
    - stop → IDLE.
  - PAUSE:
    - pos held; scan continues.
    - pause=0 → RUN.
    - stop → IDLE.
    - scroll_p is ignored.
- Length register:
  - len_we loads len = min(len_data, MSG_DEPTH).
  - If the new len = 0 while running: → IDLE, pos = 0.
  - If pos ≥ new len: pos = 0 in the same clk.
  - len < 4 is legal: digits wrap, repeating characters modulo len.
- Simultaneous events:
  - scan_p and scroll_p in the same clk: both are applied. The display register uses the old pos that clk and the new pos on the next scan_p.
  - stop and start in the same clk: stop wins.
  - start in RUN or PAUSE: ignored.
  - len_we together with scroll_p: the length update is applied first, then the wrap uses the new len.
- Reset mid-operation:
  - Immediate return to reset values.
  - Buffer contents are cleared.

Test Plan:
- Reset: assert rst_n=0 mid-RUN → seg=7'h7F, an=4'hF, running=0, pos=0 with no clk edge required. After release, buffer reads 16 at all slots.
- Edge sync: one div_scan rise held high 100 clk → exactly one digit advance, occurring 3 clk after the rise; an steps 4'hE→4'hD.
- Forward scroll: write buf[0..5] = 1,2,3,4,5,6, len=6, start. Apply 7 scroll pulses → pos sequence 1,2,3,4,5,0,1. At pos=5, digits 0..3 show 6,1,2,3.
- Backward and pause: dir=1 from pos=0 with len=6 → pos=5. Set pause=1, apply 3 scroll_p → pos remains 5. Release pause, apply next scroll_p → pos=4.
- Length shrink: with pos=5, running, write len=3 → pos=0 that clk. Write len=0 → IDLE, blanked display.
- Corners:
  - start with len=0 → remains IDLE.
  - stop and start in the same clk → IDLE.
  - Write code 17 → seg=7'h3F on that digit.
  - Write code 25 → blank.
